alarm_sequencer: RTL and testbench

Alarm controller for the digital clock. It holds the programmed alarm time and compares it against the running hour/min/sec from the timekeeping datapath. It sequences the alarm through armed, ringing and snooze phases and drives the buzzer and alarm indicators. It sits beside the timekeeper, consuming its binary time and 1 Hz strobe, with debounced, edge-detected button pulses from the board front end.

---
 rtl/alarm_sequencer_if.sv | 31 +++
 rtl/alarm_sequencer.sv | 138 +++++++++++++
 tb/tb_alarm_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer and its surroundings: time from the
// timekeeper, front-panel controls, and the alarm outputs.
interface alarm_sequencer_if;
    logic       tick_1hz;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       arm;
    logic       set_valid;
    logic [4:0] alarm_hour_in;
    logic [5:0] alarm_min_in;
    logic       dismiss;
    logic       snooze;
    logic [1:0] alarm_state;
    logic       ringing;
    logic       buzzer;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;

    modport master (
        output tick_1hz, hour, min, sec, arm, set_valid,
               alarm_hour_in, alarm_min_in, dismiss, snooze,
        input  alarm_state, ringing, buzzer, alarm_hour, alarm_min
    );

    modport slave (
        input  tick_1hz, hour, min, sec, arm, set_valid,
               alarm_hour_in, alarm_min_in, dismiss, snooze,
        output alarm_state, ringing, buzzer, alarm_hour, alarm_min
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm controller: holds the alarm time, detects the HH:MM:00 edge and sequences
// IDLE/ARMED/RINGING/SNOOZE. Snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_sequencer #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    alarm_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        RINGING = 2'b10,
        SNOOZE  = 2'b11
    } state_t;

    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 15) begin : g_bad_snooze_min
        $error("alarm_sequencer: SNOOZE_MIN must be 1..15");
    end
    if (RING_TIMEOUT_S < 2 || RING_TIMEOUT_S > 255) begin : g_bad_ring_timeout
        $error("alarm_sequencer: RING_TIMEOUT_S must be 2..255");
    end

    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

    state_t     state, state_n;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       match, match_q, trigger, load_ok;
    logic [7:0] ring_cnt, ring_cnt_n;
    logic       phase, phase_n;
    logic       ringing_q, buzzer_q;

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNZ_LOAD = 10'(SNOOZE_MIN * 60);
    logic [9:0] snz_cnt, snz_cnt_n;
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze;
`endif

    // Level match lasts the whole second; only its rising edge starts a ring.
    assign match   = (bus.hour == alarm_hour) && (bus.min == alarm_min) && (bus.sec == 6'd0);
    assign trigger = match & ~match_q;
    assign load_ok = bus.set_valid && (bus.alarm_hour_in <= 5'd23) && (bus.alarm_min_in <= 6'd59);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n    = state;
        ring_cnt_n = ring_cnt;
        phase_n    = phase;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_n  = snz_cnt;
`endif
        if (!bus.arm) begin
            state_n = IDLE;
        end else if (bus.set_valid || bus.dismiss) begin
            state_n = ARMED;
`ifdef ALARM_SNOOZE_EN
        end else if (bus.snooze && state == RINGING) begin
            state_n   = SNOOZE;
            snz_cnt_n = SNZ_LOAD;
`endif
        end else begin
            case (state)
                IDLE: state_n = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_n    = RINGING;
                        ring_cnt_n = 8'd0;
                        phase_n    = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.tick_1hz) begin
                        ring_cnt_n = ring_cnt + 8'd1;
                        phase_n    = ~phase;
                        if (ring_cnt == RING_LAST) state_n = ARMED;
                    end
                end
                SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    if (bus.tick_1hz) begin
                        snz_cnt_n = snz_cnt - 10'd1;
                        if (snz_cnt == 10'd1) begin
                            state_n    = RINGING;
                            ring_cnt_n = 8'd0;
                            phase_n    = 1'b1;
                        end
                    end
`else
                    state_n = ARMED;
`endif
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alarm_hour <= 5'd0;
            alarm_min  <= 6'd0;
            match_q    <= 1'b0;
            ring_cnt   <= 8'd0;
            phase      <= 1'b0;
            ringing_q  <= 1'b0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt    <= 10'd0;
`endif
        end else begin
            state     <= state_n;
            match_q   <= match;
            ring_cnt  <= ring_cnt_n;
            phase     <= phase_n;
            ringing_q <= (state_n == RINGING);
            buzzer_q  <= (state_n == RINGING) && phase_n;
`ifdef ALARM_SNOOZE_EN
            snz_cnt   <= snz_cnt_n;
`endif
            if (load_ok) begin
                alarm_hour <= bus.alarm_hour_in;
                alarm_min  <= bus.alarm_min_in;
            end
        end
    end

    assign bus.alarm_state = state;
    assign bus.ringing     = ringing_q;
    assign bus.buzzer      = buzzer_q;
    assign bus.alarm_hour  = alarm_hour;
    assign bus.alarm_min   = alarm_min;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed scenarios plus random traffic,
// compared each cycle against a seconds-of-day reference model.
module tb_alarm_sequencer;

    localparam int SNOOZE_MIN     = 5;
    localparam int RING_TIMEOUT_S = 60;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .SNOOZE_MIN     (SNOOZE_MIN),
        .RING_TIMEOUT_S (RING_TIMEOUT_S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       ring;
        logic       buzz;
        logic [4:0] ah;
        logic [5:0] am;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_now   = 0;
    bit   r_arm   = 1'b0;

    // Reference model state: mode, alarm time, seconds rung, seconds of snooze left.
    int   m_mode, m_ah, m_am, m_ticks, m_snz;
    bit   m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_ah = 0; m_am = 0; m_ticks = 0; m_snz = 0; m_prev = 1'b0;
    endtask

    task automatic model_step(input bit tick, input bit sv, input int hi, input int mi,
                              input bit dis, input bit snz, input int now);
        bit match, trig;
        match  = (now / 3600 == m_ah) && ((now / 60) % 60 == m_am) && (now % 60 == 0);
        trig   = match && !m_prev;
        m_prev = match;
        if (!r_arm) m_mode = M_IDLE;
        else if (sv || dis) m_mode = M_ARMED;
        else begin
`ifdef ALARM_SNOOZE_EN
            if (snz && m_mode == M_RING) begin
                m_mode = M_SNZ;
                m_snz  = SNOOZE_MIN * 60;
            end else
`endif
            case (m_mode)
                M_IDLE:  m_mode = M_ARMED;
                M_ARMED: if (trig) begin m_mode = M_RING; m_ticks = 0; end
                M_RING: if (tick) begin
                    m_ticks++;
                    if (m_ticks == RING_TIMEOUT_S) m_mode = M_ARMED;
                end
                default: begin
`ifdef ALARM_SNOOZE_EN
                    if (tick) begin
                        m_snz--;
                        if (m_snz == 0) begin m_mode = M_RING; m_ticks = 0; end
                    end
`else
                    m_mode = M_ARMED;
`endif
                end
            endcase
        end
        if (sv && hi <= 23 && mi <= 59) begin m_ah = hi; m_am = mi; end
        exp_q.push_back('{st:   2'(m_mode),
                          ring: (m_mode == M_RING),
                          buzz: (m_mode == M_RING) && (m_ticks % 2 == 0),
                          ah:   5'(m_ah),
                          am:   6'(m_am)});
    endtask

    // Called mid-cycle; drives one cycle of inputs and returns just after the edge.
    task automatic step(input bit tick, input bit sv = 1'b0, input int hi = 0, input int mi = 0,
                        input bit dis = 1'b0, input bit snz = 1'b0);
        if (tick) t_now = (t_now + 1) % 86400;
        bus.tick_1hz      = tick;
        bus.hour          = 5'(t_now / 3600);
        bus.min           = 6'((t_now / 60) % 60);
        bus.sec           = 6'(t_now % 60);
        bus.arm           = r_arm;
        bus.set_valid     = sv;
        bus.alarm_hour_in = 5'(hi);
        bus.alarm_min_in  = 6'(mi);
        bus.dismiss       = dis;
        bus.snooze        = snz;
        model_step(tick, sv, hi, mi, dis, snz, t_now);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_pulses();
        bus.tick_1hz = 1'b0; bus.set_valid = 1'b0; bus.dismiss = 1'b0; bus.snooze = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_state",   bus.alarm_state, 0);
        check("async_rst_ringing", bus.ringing, 0);
        check("async_rst_buzzer",  bus.buzzer, 0);
        exp_q.delete();
        model_reset();
        r_arm = 1'b0;
        bus.arm = 1'b0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("post_rst_state", bus.alarm_state, 0);
        check("post_rst_hour",  bus.alarm_hour, 0);
        check("post_rst_min",   bus.alarm_min, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_state",   bus.alarm_state, mon_e.st);
            check("sb_ringing", bus.ringing,     mon_e.ring);
            check("sb_buzzer",  bus.buzzer,      mon_e.buzz);
            check("sb_hour",    bus.alarm_hour,  mon_e.ah);
            check("sb_min",     bus.alarm_min,   mon_e.am);
        end
    end

    initial begin
        model_reset();
        bus.arm = 1'b0; bus.hour = '0; bus.min = '0; bus.sec = '0;
        bus.alarm_hour_in = '0; bus.alarm_min_in = '0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #2;
        check("rst_state",   bus.alarm_state, 0);
        check("rst_ringing", bus.ringing, 0);
        check("rst_buzzer",  bus.buzzer, 0);
        check("rst_hour",    bus.alarm_hour, 0);
        check("rst_min",     bus.alarm_min, 0);
        rst_n = 1'b1;

        // Auto-stop after the ring timeout.
        r_arm = 1'b1;
        step(0, 1, 7, 30);
        t_now = 7 * 3600 + 29 * 60 + 58;
        step(0);
        step(1);
        step(1);
        check("trig_ringing", bus.ringing, 1);
        check("trig_buzzer",  bus.buzzer, 1);
        for (int i = 1; i <= RING_TIMEOUT_S; i++) begin
            step(0);
            step(1);
            if (i == RING_TIMEOUT_S - 1) check("pre_timeout_state", bus.alarm_state, M_RING);
        end
        check("timeout_state",  bus.alarm_state, M_ARMED);
        check("timeout_buzzer", bus.buzzer, 0);

        // Snooze (or its absence), then dismiss inside 07:30:00 without retrigger.
        t_now = 7 * 3600 + 29 * 60 + 59;
        step(1);
        step(0, 0, 0, 0, 0, 1);
`ifdef ALARM_SNOOZE_EN
        check("snooze_state", bus.alarm_state, M_SNZ);
        for (int i = 1; i < SNOOZE_MIN * 60; i++) step(1);
        check("snooze_hold", bus.alarm_state, M_SNZ);
        step(1);
        check("snooze_return", bus.alarm_state, M_RING);
`else
        check("snooze_ignored", bus.alarm_state, M_RING);
        repeat (3) step(1);
        check("snooze_ignored_ring", bus.ringing, 1);
`endif
        t_now = 7 * 3600 + 30 * 60;
        step(0);
        step(0, 0, 0, 0, 1);
        check("dismiss_state", bus.alarm_state, M_ARMED);
        repeat (5) step(0);
        check("no_retrigger", bus.alarm_state, M_ARMED);

        // Range-checked loads.
        step(0, 1, 24, 10);
        check("bad_hour_h", bus.alarm_hour, 7);
        check("bad_hour_m", bus.alarm_min, 30);
        step(0, 1, 5, 60);
        check("bad_min_h", bus.alarm_hour, 7);
        check("bad_min_m", bus.alarm_min, 30);
        step(0, 1, 23, 59);
        check("load_2359_h", bus.alarm_hour, 23);
        check("load_2359_m", bus.alarm_min, 59);

        // Disarm beats dismiss and tick.
        step(0, 1, 7, 30);
        t_now = 7 * 3600 + 29 * 60 + 59;
        step(1);
        check("ring_before_disarm", bus.ringing, 1);
        r_arm = 1'b0;
        step(1, 0, 0, 0, 1);
        check("disarm_state",   bus.alarm_state, M_IDLE);
        check("disarm_ringing", bus.ringing, 0);

        // Reset while ringing.
        r_arm = 1'b1;
        t_now = 7 * 3600 + 29 * 60 + 59;
        step(0);
        step(1);
        check("ring_before_reset", bus.ringing, 1);
        do_reset();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            bit tk, sv, ds, sz;
            int hi, mi;
            r_arm = ($urandom_range(99) < 95);
            tk = $urandom_range(1);
            sv = ($urandom_range(99) < 2);
            hi = $urandom_range(25);
            mi = $urandom_range(61);
            ds = ($urandom_range(199) == 0);
            sz = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 2)
                t_now = (m_ah * 3600 + m_am * 60 - 1 + 86400) % 86400;
            else if ($urandom_range(499) == 0)
                t_now = $urandom_range(86399);
            step(tk, sv, hi, mi, ds, sz);
        end

        clear_pulses();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
